// File: rtl/imem_loader.sv
// Boot loader: parses a byte stream (count header, big-endian words, XOR checksum)
// into instruction-memory writes and holds the MIPS core in reset until the image verifies.
module imem_loader #(
    parameter int IMEM_DEPTH  = 256,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [31:0]            imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;

    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(IMEM_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] ONE_C   = COUNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_hi_q, cnt_hi_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [23:0]            word_buf_q, word_buf_d;
    logic [7:0]             csum_q, csum_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   imem_we_q, imem_we_d;
    logic [31:0]            imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   core_reset_q, core_reset_d;
    logic                   load_done_q, load_done_d;
    logic                   load_error_q, load_error_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;

    logic                   accept;
    logic [COUNT_WIDTH-1:0] hdr_count;
    logic [COUNT_WIDTH-1:0] words_next;

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        words_d      = words_q;
        accept       = rx_valid && rx_ready_q;
        hdr_count    = COUNT_WIDTH'({cnt_hi_q, rx_data});
        words_next   = words_q + ONE_C;

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    cnt_hi_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    count_d = hdr_count;
                    csum_d  = csum_q ^ rx_data;
                    if (hdr_count > DEPTH_C) begin
                        state_d = ERR;
                    end else if (hdr_count == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (byte_idx_q == 2'd3) begin
                        // Final byte completes the word: strobe it out at the current word index.
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {word_buf_q, rx_data};
                        imem_addr_d  = 32'({words_q, 2'b00});
                        words_d      = words_next;
                        byte_idx_d   = 2'd0;
                        if (words_next == count_q) begin
                            state_d = CHK;
                        end
                    end else begin
                        word_buf_d = {word_buf_q[15:0], rx_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d    = HDR_HI;
                    words_d    = '0;
                    csum_d     = 8'h00;
                    byte_idx_d = 2'd0;
                end
            end
            default: state_d = HDR_HI;
        endcase

        // Status outputs are decoded from the next state so they register alongside it.
        rx_ready_d   = (state_d != DONE) && (state_d != ERR);
        core_reset_d = (state_d != DONE);
        load_done_d  = (state_d == DONE);
        load_error_d = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HDR_HI;
            cnt_hi_q     <= 8'h00;
            count_q      <= '0;
            byte_idx_q   <= 2'd0;
            word_buf_q   <= 24'h0;
            csum_q       <= 8'h00;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'h0;
            imem_wdata_q <= 32'h0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            csum_q       <= csum_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            words_q      <= words_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule
